// File: rtl/logic_reduce_acc_if.sv
// Stream bundle for logic_reduce_acc: beat input channel and frame-result output channel.
// The DUT takes the slave side; the producer/consumer pair takes the master side.
interface logic_reduce_acc_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              in_op;
    logic                    in_last;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CNT_W-1:0]        out_beats;
    logic [1:0]              out_op;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_op, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_beats, out_op, out_valid
    );

    modport slave (
        input  in_data, in_op, in_last, in_valid, out_ready,
        output in_ready, out_data, out_beats, out_op, out_valid
    );
endinterface

// File: rtl/logic_reduce_acc.sv
// Multi-lane AND/OR/XOR/NAND reducer that folds a multi-beat frame into one registered
// result, handed downstream over valid/ready with a saturating beat count.
module logic_reduce_acc #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    logic_reduce_acc_if.slave  bus
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // NAND folds as AND; the inversion is applied once, when the result is registered.
    function automatic logic [WIDTH-1:0] base_combine(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = a & b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_beats_r;
    logic [1:0]       out_op_r;
    logic             out_valid_r;

    logic             first_s;
    logic             accept_s;
    logic             last_accept_s;
    logic [1:0]       op_eff_s;
    logic [WIDTH-1:0] lane_res_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [WIDTH-1:0] result_s;

    // The only combinational in-to-out path is out_ready feeding in_ready.
    assign bus.in_ready  = !out_valid_r || bus.out_ready;
    assign bus.out_data  = out_data_r;
    assign bus.out_beats = out_beats_r;
    assign bus.out_op    = out_op_r;
    assign bus.out_valid = out_valid_r;

    assign first_s       = (state_r == ST_IDLE);
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign last_accept_s = accept_s && bus.in_last;

    // Beat datapath: op selection, lane reduction, accumulator and counter next values.
    always_comb begin
        op_eff_s   = op_r;
        lane_res_s = bus.in_data[WIDTH-1:0];
        acc_next_s = acc_r;
        cnt_next_s = cnt_r;
        result_s   = acc_r;
        if (first_s) begin
            op_eff_s = bus.in_op;
        end else begin
            op_eff_s = op_r;
        end
        for (int k = 1; k < NUM_IN; k++) begin
            lane_res_s = base_combine(lane_res_s, bus.in_data[k*WIDTH +: WIDTH], op_eff_s);
        end
        if (first_s) begin
            acc_next_s = lane_res_s;
            cnt_next_s = CNT_W'(1);
        end else begin
            acc_next_s = base_combine(acc_r, lane_res_s, op_eff_s);
            if (cnt_r == {CNT_W{1'b1}}) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end
        if (op_eff_s == OP_NAND) begin
            result_s = ~acc_next_s;
        end else begin
            result_s = acc_next_s;
        end
    end

    // Frame state: open on a non-last accept, close on a last accept.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !bus.in_last) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, accumulator and output result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_beats_r <= '0;
            out_op_r    <= 2'b00;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_next_s;
                op_r  <= op_eff_s;
            end
            // A new result may reload in the same cycle the previous one is taken.
            if (last_accept_s) begin
                out_data_r  <= result_s;
                out_beats_r <= cnt_next_s;
                out_op_r    <= op_eff_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed bench for logic_reduce_acc: a default-width instance plus a CNT_W=2 instance
// for count saturation, each scenario in its own task with inline expected values.
module tb_logic_reduce_acc;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    logic_reduce_acc_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) bus1 ();
    logic_reduce_acc_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) bus2 ();

    logic_reduce_acc #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    logic_reduce_acc #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat on dut1 for one cycle (ready is assumed), then drop in_valid.
    task automatic beat1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic last);
        bus1.in_data  = {b, a};
        bus1.in_op    = op;
        bus1.in_last  = last;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus1.out_valid); end
        n_cmp++; if (bus1.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd0) begin n_fail++; $display("FAIL rst_beats: got %0d want 0", bus1.out_beats); end
        n_cmp++; if (bus1.out_op !== 2'b00) begin n_fail++; $display("FAIL rst_op: got %b want 00", bus1.out_op); end
        n_cmp++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus1.in_ready); end
    endtask

    task automatic pop1();
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid: got %b want 0", bus1.out_valid); end
    endtask

    task automatic test_single_and();
        beat1(8'hA5, 8'h0F, 2'b00, 1'b1);
        n_cmp++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL and1_valid: got %b want 1", bus1.out_valid); end
        n_cmp++; if (bus1.out_data !== 8'h05) begin n_fail++; $display("FAIL and1_data: got %h want 05", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd1) begin n_fail++; $display("FAIL and1_beats: got %0d want 1", bus1.out_beats); end
        n_cmp++; if (bus1.out_op !== 2'b00) begin n_fail++; $display("FAIL and1_op: got %b want 00", bus1.out_op); end
        pop1();
    endtask

    task automatic test_xor_frame();
        beat1(8'hFF, 8'h00, 2'b10, 1'b0);
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_early_valid: got %b want 0", bus1.out_valid); end
        beat1(8'h0F, 8'h00, 2'b01, 1'b0);
        // bubble with junk on the bus must leave acc and count alone
        bus1.in_data = 16'hFFFF;
        tick();
        beat1(8'h01, 8'h00, 2'b01, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'hF1) begin n_fail++; $display("FAIL xor_data: got %h want F1", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd3) begin n_fail++; $display("FAIL xor_beats: got %0d want 3", bus1.out_beats); end
        n_cmp++; if (bus1.out_op !== 2'b10) begin n_fail++; $display("FAIL xor_op: got %b want 10", bus1.out_op); end
        pop1();
    endtask

    task automatic test_nand_or();
        beat1(8'hFF, 8'hF0, 2'b11, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'h0F) begin n_fail++; $display("FAIL nand_data: got %h want 0F", bus1.out_data); end
        n_cmp++; if (bus1.out_op !== 2'b11) begin n_fail++; $display("FAIL nand_op: got %b want 11", bus1.out_op); end
        pop1();
        beat1(8'h00, 8'h01, 2'b01, 1'b0);
        beat1(8'h80, 8'h00, 2'b00, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'h81) begin n_fail++; $display("FAIL or_data: got %h want 81", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd2) begin n_fail++; $display("FAIL or_beats: got %0d want 2", bus1.out_beats); end
        // result 81 is left pending for the backpressure scenario
    endtask

    task automatic test_backpressure();
        bus1.out_ready = 1'b0;
        bus1.in_data   = {8'h22, 8'h11};
        bus1.in_op     = 2'b01;
        bus1.in_last   = 1'b1;
        bus1.in_valid  = 1'b1;
        #1;
        n_cmp++; if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus1.in_ready); end
        tick();
        tick();
        n_cmp++; if (bus1.out_data !== 8'h81) begin n_fail++; $display("FAIL bp_hold_data: got %h want 81", bus1.out_data); end
        n_cmp++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", bus1.out_valid); end
        bus1.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus1.in_ready); end
        tick();
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        n_cmp++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid: got %b want 1", bus1.out_valid); end
        n_cmp++; if (bus1.out_data !== 8'h33) begin n_fail++; $display("FAIL bp_reload_data: got %h want 33", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd1) begin n_fail++; $display("FAIL bp_reload_beats: got %0d want 1", bus1.out_beats); end
        tick();
        n_cmp++; if (bus1.out_data !== 8'h33) begin n_fail++; $display("FAIL bp_hold2_data: got %h want 33", bus1.out_data); end
        pop1();
    endtask

    task automatic test_back_to_back();
        bus1.out_ready = 1'b1;
        beat1(8'hF0, 8'h3C, 2'b00, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'h30) begin n_fail++; $display("FAIL b2b0_data: got %h want 30", bus1.out_data); end
        beat1(8'h01, 8'h02, 2'b01, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'h03) begin n_fail++; $display("FAIL b2b1_data: got %h want 03", bus1.out_data); end
        beat1(8'hFF, 8'h0F, 2'b10, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'hF0) begin n_fail++; $display("FAIL b2b2_data: got %h want F0", bus1.out_data); end
        n_cmp++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b2_valid: got %b want 1", bus1.out_valid); end
        tick();
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %b want 0", bus1.out_valid); end
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        bus2.out_ready = 1'b0;
        bus2.in_data   = 16'hFFFF;
        bus2.in_op     = 2'b00;
        bus2.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus2.in_last = (i == 5);
            tick();
        end
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
        n_cmp++; if (bus2.out_beats !== 2'd3) begin n_fail++; $display("FAIL sat_beats: got %0d want 3", bus2.out_beats); end
        n_cmp++; if (bus2.out_data !== 8'hFF) begin n_fail++; $display("FAIL sat_data: got %h want FF", bus2.out_data); end
        n_cmp++; if (bus2.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b want 1", bus2.out_valid); end
    endtask

    task automatic test_mid_reset();
        bus1.out_ready = 1'b1;
        beat1(8'hFF, 8'hFF, 2'b00, 1'b0);
        beat1(8'h0F, 8'hFF, 2'b00, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", bus1.out_valid); end
        beat1(8'h12, 8'h40, 2'b01, 1'b1);
        n_cmp++; if (bus1.out_data !== 8'h52) begin n_fail++; $display("FAIL mrst_data: got %h want 52", bus1.out_data); end
        n_cmp++; if (bus1.out_beats !== 8'd1) begin n_fail++; $display("FAIL mrst_beats: got %0d want 1", bus1.out_beats); end
        n_cmp++; if (bus1.out_op !== 2'b01) begin n_fail++; $display("FAIL mrst_op: got %b want 01", bus1.out_op); end
        tick();
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_drain: got %b want 0", bus1.out_valid); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus1.in_data = '0; bus1.in_op = 2'b00; bus1.in_last = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_data = '0; bus2.in_op = 2'b00; bus2.in_last = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        test_reset();
        test_single_and();
        test_xor_frame();
        test_nand_or();
        test_backpressure();
        test_back_to_back();
        test_saturate();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_reduce_acc.md
# logic_reduce_acc

Parametrised registered logic unit; the next generation of the team's single-bit registered AND cell. Combines NUM_IN lanes of WIDTH bits with a runtime-selected operation (AND/OR/XOR/NAND), accumulates the per-beat result across a multi-beat frame, and emits one registered result per frame over a valid/ready handshake. Sits between streaming test-pattern sources and compare/checker logic in the FPGA regression designs.

## Interface
- WIDTH, 8, bits per lane and result width (≥1)
- NUM_IN, 2, number of input lanes (≥2)
- CNT_W, 8, width of the frame beat counter (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; sampled on the clk rising edge
- in_data  input  NUM_IN*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on the first beat of a frame only
- in_last  input  1  marks the final beat of a frame
- in_valid  input  1  beat present
- in_ready  output  1  beat accepted when in_valid && in_ready
- out_data  output  WIDTH  frame result
- out_beats  output  CNT_W  beats in the frame, saturating at 2^CNT_W−1
- out_op  output  2  op used for the frame
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts when out_valid && out_ready

## Operation
- Lane combine per beat: AND/NAND → bitwise AND of all lanes; OR → bitwise OR; XOR → bitwise XOR.
- Frame accumulate with the same base op (AND for NAND): the first beat loads acc = lane result; subsequent beats set acc = acc op lane result.
- Op latch: on a first-beat accept, op_q ← in_op. in_op on later beats of the frame is ignored.
- State: IDLE (no frame open, first_q=1) and ACCUM (frame open, first_q=0). IDLE→ACCUM on accept with in_last=0. ACCUM→IDLE on accept with in_last=1. Accept with in_last=1 in IDLE is a one-beat frame; state stays IDLE.
- On a last-beat accept: out_data ← final acc (inverted if op_q or in_op on a first beat is NAND); out_beats ← beat count including this beat; out_op ← frame op; out_valid ← 1.
- Beat counter: cleared at frame start, increments per accept, saturates at all-ones (no wrap).
- in_ready = !out_valid || out_ready. This is combinational and applies to all beats, so backpressure stalls the whole frame.
- out_valid clears on an out_ready handshake unless a new last beat is accepted in the same cycle. In that case the register reloads and out_valid stays 1.
- out_data, out_beats and out_op hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_beats=0, out_op=0, acc=0, count=0, state IDLE. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-frame discards the partial frame and any pending output. No result is emitted for it.
- Latency: last beat accepted at edge T → out_valid=1 from edge T, visible in cycle T+1.
- Throughput: one beat per cycle. Back-to-back one-beat frames stream at 1/cycle with out_ready held 1.
- in_valid=0 cycles within a frame are bubbles: acc and count hold.
- No combinational path from in_* to out_*. The only combinational path is out_ready→in_ready.

## Test plan
- Reset, then one beat with WIDTH=8, NUM_IN=2, lanes A5/0F, op AND, last=1 → next cycle out_data=05, out_beats=1, out_op=00, out_valid=1.
- 3-beat XOR frame, lane pairs (FF,00), (0F,00), (01,00), with in_op changed to OR on beat 2 → out_data=F1, out_beats=3, out_op=10.
- NAND one-beat frame, lanes FF/F0 → out_data=0F. Then an OR frame of 2 beats, (00,01) and (80,00) → out_data=81.
- out_ready=0 with result pending and new beats offered → in_ready=0, outputs hold. Raise out_ready simultaneously with a last beat → out_valid stays 1 with the new result, and no frame is lost or duplicated.
- CNT_W=2, 6-beat AND frame with all lanes FF → out_beats=3 (saturated), out_data=FF.
- Reset asserted after beat 2 of a 4-beat frame, then a fresh one-beat OR frame 12/40 → only out_data=52, out_beats=1 is emitted.
